// File: rtl/pong_ball_ctrl.sv
// Ball motion and goal detection for pong: advances the ball once per frame_tick,
// bounces off walls and paddles, pulses player_Scored / cpu_Scored on a goal.
module pong_ball_ctrl #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PLAYER_X     = 16,
    parameter int CPU_X        = 616,
    parameter int SPEED        = 2,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [9:0] player_y,
    input  logic [9:0] cpu_y,
    input  logic       player_Win,
    input  logic       cpu_Win,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_visible,
    output logic       player_Scored,
    output logic       cpu_Scored
);

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    // 12-bit signed so that paddle_y + PADDLE_H and nx - SPEED never wrap.
    localparam logic signed [11:0] C_ZERO     = 12'(0);
    localparam logic signed [11:0] C_SPEED    = 12'(SPEED);
    localparam logic signed [11:0] C_BALL     = 12'(BALL_SIZE);
    localparam logic signed [11:0] C_PAD_H    = 12'(PADDLE_H);
    localparam logic signed [11:0] C_Y_MAX    = 12'(V_RES - BALL_SIZE);
    localparam logic signed [11:0] C_X_MAX    = 12'(H_RES - BALL_SIZE);
    localparam logic signed [11:0] C_PL_EDGE  = 12'(PLAYER_X + PADDLE_W);
    localparam logic signed [11:0] C_CPU_EDGE = 12'(CPU_X);

    localparam logic [9:0] X_CENTRE = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0] Y_CENTRE = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [9:0] X_LEFT   = 10'(0);
    localparam logic [9:0] X_RIGHT  = 10'(H_RES - BALL_SIZE);
    localparam logic [9:0] Y_TOP    = 10'(0);
    localparam logic [9:0] Y_BOTTOM = 10'(V_RES - BALL_SIZE);
    localparam logic [9:0] X_PL_HIT = 10'(PLAYER_X + PADDLE_W);
    localparam logic [9:0] X_CPU_HIT = 10'(CPU_X - BALL_SIZE);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {S_SERVE, S_PLAY, S_GOAL, S_OVER} state_t;

    state_t           r_state;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_dx_neg;
    logic             r_dy_neg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_visible;
    logic             r_player_scored;
    logic             r_cpu_scored;

    logic signed [11:0] w_x, w_y, w_nx, w_ny, w_py, w_cy;
    logic               w_pl_overlap, w_cpu_overlap;
    logic               w_pl_hit, w_cpu_hit;
    logic               w_goal_left, w_goal_right;

    assign w_x  = signed'({2'b00, r_x});
    assign w_y  = signed'({2'b00, r_y});
    assign w_py = signed'({2'b00, player_y});
    assign w_cy = signed'({2'b00, cpu_y});
    assign w_nx = r_dx_neg ? w_x - C_SPEED : w_x + C_SPEED;
    assign w_ny = r_dy_neg ? w_y - C_SPEED : w_y + C_SPEED;

    // Overlap uses the current y, not the stepped one.
    assign w_pl_overlap  = (w_y + C_BALL > w_py) && (w_y < w_py + C_PAD_H);
    assign w_cpu_overlap = (w_y + C_BALL > w_cy) && (w_y < w_cy + C_PAD_H);

    assign w_pl_hit  = r_dx_neg && (w_x >= C_PL_EDGE) && (w_nx <= C_PL_EDGE) && w_pl_overlap;
    assign w_cpu_hit = !r_dx_neg && (w_x + C_BALL <= C_CPU_EDGE) &&
                       (w_nx + C_BALL >= C_CPU_EDGE) && w_cpu_overlap;

    assign w_goal_left  = !w_pl_hit && !w_cpu_hit && (w_nx <= C_ZERO);
    assign w_goal_right = !w_pl_hit && !w_cpu_hit && (w_nx >= C_X_MAX);

    // NOTE: every register here is state, so all assignments are non-blocking;
    // reading r_* anywhere in this block sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_SERVE;
            r_x             <= X_CENTRE;
            r_y             <= Y_CENTRE;
            r_dx_neg        <= 1'b0;
            r_dy_neg        <= 1'b0;
            r_cnt           <= CNT_LOAD;
            r_visible       <= 1'b1;
            r_player_scored <= 1'b0;
            r_cpu_scored    <= 1'b0;
        end else begin
            r_player_scored <= 1'b0;
            r_cpu_scored    <= 1'b0;
            if (frame_tick) begin
                case (r_state)
                    S_SERVE: begin
                        r_cnt <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) r_state <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (w_goal_left || w_goal_right) begin
                            // y is frozen; dx is preloaded toward the conceding side for the serve.
                            r_x             <= w_goal_left ? X_LEFT : X_RIGHT;
                            r_dx_neg        <= w_goal_left;
                            r_cpu_scored    <= w_goal_left;
                            r_player_scored <= w_goal_right;
                            r_state         <= S_GOAL;
                        end else begin
                            if (w_pl_hit) begin
                                r_x      <= X_PL_HIT;
                                r_dx_neg <= 1'b0;
                            end else if (w_cpu_hit) begin
                                r_x      <= X_CPU_HIT;
                                r_dx_neg <= 1'b1;
                            end else begin
                                r_x <= w_nx[9:0];
                            end
                            if (w_ny <= C_ZERO) begin
                                r_y      <= Y_TOP;
                                r_dy_neg <= 1'b0;
                            end else if (w_ny >= C_Y_MAX) begin
                                r_y      <= Y_BOTTOM;
                                r_dy_neg <= 1'b1;
                            end else begin
                                r_y <= w_ny[9:0];
                            end
                        end
                    end
                    S_GOAL: begin
                        if (player_Win || cpu_Win) begin
                            r_state   <= S_OVER;
                            r_visible <= 1'b0;
                        end else begin
                            r_state  <= S_SERVE;
                            r_x      <= X_CENTRE;
                            r_y      <= Y_CENTRE;
                            r_dy_neg <= 1'b0;
                            r_cnt    <= CNT_LOAD;
                        end
                    end
                    S_OVER: begin
                        r_state <= S_OVER;
                    end
                endcase
            end
        end
    end

    assign ball_x        = r_x;
    assign ball_y        = r_y;
    assign ball_visible  = r_visible;
    assign player_Scored = r_player_scored;
    assign cpu_Scored    = r_cpu_scored;

endmodule
